// File: rtl/flag_branch_unit.sv
// flag_branch_unit: PC sequencer with flag-conditioned branches.
// Branches resolve through an IDLE -> EVAL -> REDIRECT FSM.
module flag_branch_unit #(
  parameter int ADDR_W = 8,
  parameter int FLAG_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [FLAG_W-1:0] Flagin,
  input  logic              BrReq,
  input  logic [4:0]        BrCond,
  input  logic [ADDR_W-1:0] BrTarget,
  input  logic              Stall,
  output logic [ADDR_W-1:0] PC,
  output logic              BrBusy,
  output logic              BrTaken,
  output logic [FLAG_W-1:0] FlagSnap
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVAL     = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [4:0]          cond_q, cond_d;
  logic [ADDR_W-1:0]   tgt_q, tgt_d;
  logic [FLAG_W-1:0]   snap_q, snap_d;
  logic                taken_q, taken_d;
  logic                flag_bit;
  logic                br_take;

  // Condition: unconditional, or selected flag xor negate.
  always_comb begin
    flag_bit = Flagin[cond_q[2:0]];
    br_take  = cond_q[4] | (flag_bit ^ cond_q[3]);
  end

  // Next-state, PC and latch update; a stall freezes everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cond_d  = cond_q;
    tgt_d   = tgt_q;
    snap_d  = snap_q;
    taken_d = 1'b0;
    if (!Stall) begin
      unique case (state_q)
        IDLE: begin
          if (BrReq) begin
            cond_d  = BrCond;
            tgt_d   = BrTarget;
            state_d = EVAL;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
        EVAL: begin
          snap_d = Flagin;
          if (br_take) begin
            state_d = REDIRECT;
          end else begin
            state_d = IDLE;
            pc_d    = pc_q + 1'b1;
          end
        end
        REDIRECT: begin
          pc_d    = tgt_q;
          taken_d = 1'b1;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cond_q  <= '0;
      tgt_q   <= '0;
      snap_q  <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cond_q  <= cond_d;
      tgt_q   <= tgt_d;
      snap_q  <= snap_d;
      taken_q <= taken_d;
    end
  end

  // Busy whenever a branch is in flight.
  always_comb begin
    BrBusy = (state_q == EVAL) || (state_q == REDIRECT);
  end

  assign PC       = pc_q;
  assign BrTaken  = taken_q;
  assign FlagSnap = snap_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// tb_flag_branch_unit: directed vectors, scoreboard queue.
// Stimulus pushes expectations; a monitor pops and compares.
module tb_flag_branch_unit;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] Flagin = '0;
  logic       BrReq = 1'b0;
  logic [4:0] BrCond = '0;
  logic [7:0] BrTarget = '0;
  logic       Stall = 1'b0;
  logic [7:0] PC;
  logic       BrBusy;
  logic       BrTaken;
  logic [7:0] FlagSnap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] pc;
    logic       busy;
    logic       taken;
    logic [7:0] snap;
  } exp_t;

  exp_t sb[$];

  flag_branch_unit #(.ADDR_W(8), .FLAG_W(8)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Flagin(Flagin),
    .BrReq(BrReq),
    .BrCond(BrCond),
    .BrTarget(BrTarget),
    .Stall(Stall),
    .PC(PC),
    .BrBusy(BrBusy),
    .BrTaken(BrTaken),
    .FlagSnap(FlagSnap)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input string fld,
                     input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs are presented every edge; sample 1ns after.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.name, "pc", PC, e.pc);
      chk(e.name, "busy", {7'd0, BrBusy}, {7'd0, e.busy});
      chk(e.name, "taken", {7'd0, BrTaken}, {7'd0, e.taken});
      chk(e.name, "snap", FlagSnap, e.snap);
    end
  end

  task automatic cyc(input logic rst, input logic req,
                     input logic [4:0] cnd, input logic [7:0] tgt,
                     input logic [7:0] flg, input logic stl,
                     input logic [7:0] epc, input logic ebusy,
                     input logic etaken, input logic [7:0] esnap,
                     input string nm);
    exp_t e;
    @(negedge Clk);
    Reset    = rst;
    BrReq    = req;
    BrCond   = cnd;
    BrTarget = tgt;
    Flagin   = flg;
    Stall    = stl;
    e.name  = nm;
    e.pc    = epc;
    e.busy  = ebusy;
    e.taken = etaken;
    e.snap  = esnap;
    sb.push_back(e);
  endtask

  initial begin
    // reset, free run
    cyc(0, 0, 5'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, "rst0");
    cyc(0, 0, 5'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, "rst1");
    cyc(1, 0, 5'h00, 8'h00, 8'h00, 0, 8'h01, 0, 0, 8'h00, "run1");
    cyc(1, 0, 5'h00, 8'h00, 8'h00, 0, 8'h02, 0, 0, 8'h00, "run2");
    cyc(1, 0, 5'h00, 8'h00, 8'h00, 0, 8'h03, 0, 0, 8'h00, "run3");
    // unconditional jump to FE, then wrap
    cyc(1, 1, 5'h10, 8'hFE, 8'h00, 0, 8'h03, 1, 0, 8'h00, "jfe_req");
    cyc(1, 0, 5'h00, 8'h00, 8'h00, 0, 8'h03, 1, 0, 8'h00, "jfe_eval");
    cyc(1, 0, 5'h00, 8'h00, 8'h00, 0, 8'hFE, 0, 1, 8'h00, "jfe_load");
    cyc(1, 0, 5'h00, 8'h00, 8'h00, 0, 8'hFF, 0, 0, 8'h00, "wrap_ff");
    cyc(1, 0, 5'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, "wrap_00");
    for (int i = 1; i <= 5; i++)
      cyc(1, 0, 5'h00, 8'h00, 8'h00, 0, 8'(i), 0, 0, 8'h00, "run_to5");
    // taken conditional on bit 2
    cyc(1, 1, 5'h02, 8'h40, 8'h04, 0, 8'h05, 1, 0, 8'h00, "tk_req");
    cyc(1, 0, 5'h00, 8'h00, 8'h04, 0, 8'h05, 1, 0, 8'h04, "tk_eval");
    cyc(1, 0, 5'h00, 8'h00, 8'h04, 0, 8'h40, 0, 1, 8'h04, "tk_load");
    cyc(1, 0, 5'h00, 8'h00, 8'h04, 0, 8'h41, 0, 0, 8'h04, "tk_after");
    // unconditional to A0 with flags clear
    cyc(1, 1, 5'h10, 8'hA0, 8'h00, 0, 8'h41, 1, 0, 8'h04, "unc_req");
    cyc(1, 0, 5'h00, 8'h00, 8'h00, 0, 8'h41, 1, 0, 8'h00, "unc_eval");
    cyc(1, 0, 5'h00, 8'h00, 8'h00, 0, 8'hA0, 0, 1, 8'h00, "unc_load");
    // not taken: bit 2 of 03 is 0
    cyc(1, 1, 5'h02, 8'h40, 8'h03, 0, 8'hA0, 1, 0, 8'h00, "nt_req");
    cyc(1, 0, 5'h00, 8'h00, 8'h03, 0, 8'hA1, 0, 0, 8'h03, "nt_eval");
    // negated: back-to-back request, taken
    cyc(1, 1, 5'h0A, 8'h40, 8'h03, 0, 8'hA1, 1, 0, 8'h03, "neg_req");
    cyc(1, 0, 5'h00, 8'h00, 8'h03, 0, 8'hA1, 1, 0, 8'h03, "neg_eval");
    cyc(1, 0, 5'h00, 8'h00, 8'h03, 0, 8'h40, 0, 1, 8'h03, "neg_load");
    // stall three cycles in EVAL; flags moved to prove hold
    cyc(1, 1, 5'h01, 8'h80, 8'h02, 0, 8'h40, 1, 0, 8'h03, "st_req");
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 5'h10, 8'h11, 8'h00, 1, 8'h40, 1, 0, 8'h03, "st_hold");
    cyc(1, 0, 5'h00, 8'h00, 8'h02, 0, 8'h40, 1, 0, 8'h02, "st_eval");
    cyc(1, 0, 5'h00, 8'h00, 8'h02, 0, 8'h80, 0, 1, 8'h02, "st_load");
    // request during stall in IDLE is dropped; BrTaken forced low
    cyc(1, 1, 5'h10, 8'h11, 8'h02, 1, 8'h80, 0, 0, 8'h02, "st_drop");
    cyc(1, 0, 5'h00, 8'h00, 8'h02, 0, 8'h81, 0, 0, 8'h02, "st_free");
    // reset (with stall) in REDIRECT aborts the branch
    cyc(1, 1, 5'h10, 8'h40, 8'h02, 0, 8'h81, 1, 0, 8'h02, "rm_req");
    cyc(1, 0, 5'h00, 8'h40, 8'h02, 0, 8'h81, 1, 0, 8'h02, "rm_eval");
    cyc(0, 0, 5'h00, 8'h40, 8'h02, 1, 8'h00, 0, 0, 8'h00, "rm_rst");
    cyc(1, 0, 5'h00, 8'h40, 8'h02, 0, 8'h01, 0, 0, 8'h00, "rm_after");
    cyc(1, 0, 5'h00, 8'h40, 8'h02, 0, 8'h02, 0, 0, 8'h00, "rm_run");
    begin
      int n = 0;
      while (sb.size() > 0 && n < 10) begin
        @(posedge Clk);
        n++;
      end
      #2;
      if (sb.size() > 0) begin
        errors++;
        $display("FAIL drain queue left %0d expected 0", sb.size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Program-counter and conditional-branch sequencer that consumes the 8-bit flag vector produced by the Flag register (its `Flagout` drives this block's `Flagin`). It advances the PC on every unstalled cycle and services branch requests with a three-state FSM. Each request samples the stored flags, evaluates the condition, and either redirects the PC to the branch target or falls through. It sits between the instruction decoder and the instruction memory address port.

## Interface
- `ADDR_W`, default 8: PC and branch-target width.
- `FLAG_W`, default 8: flag vector width. Must be 8, since the condition index is 3 bits.
- `Clk`  input  1: single clock. All state updates on rising edge.
- `Reset`  input  1: synchronous, active-low reset. Sampled on `Clk` rising edge only.
- `Flagin`  input  FLAG_W: stored flags, connected to the Flag register output.
- `BrReq`  input  1: branch request from the decoder. Accepted only in IDLE with `Stall`=0.
- `BrCond`  input  5: condition code, latched with `BrReq`.
  - [4]: unconditional.
  - [3]: negate.
  - [2:0]: flag bit index.
- `BrTarget`  input  ADDR_W: branch destination, latched with `BrReq`.
- `Stall`  input  1: freezes PC, FSM and latches.
- `PC`  output  ADDR_W: registered program counter.
- `BrBusy`  output  1: high in EVAL or REDIRECT. Decoded combinationally from the state.
- `BrTaken`  output  1: registered one-cycle pulse, high in the cycle after the PC is loaded with the target.
- `FlagSnap`  output  FLAG_W: registered copy of `Flagin` taken at evaluation.

## Operation
- **States:** IDLE, EVAL, REDIRECT. Binary encoded. Illegal encodings go to IDLE.
- **Reset** (`Reset`=0 at an edge): `PC`=0, state=IDLE, `BrTaken`=0, `FlagSnap`=0, latched condition and target=0. `BrBusy`=0 follows from the state.
- **Stall priority:** `Stall`=1 (reset inactive) holds `PC`, state, latches and `FlagSnap`. `BrTaken` is forced 0. A `BrReq` during a stall is dropped, not queued.
- **IDLE, `BrReq`=0:** `PC` <= `PC`+1, modulo 2^ADDR_W (8'hFF -> 8'h00).
- **IDLE, `BrReq`=1:** latch `BrCond` and `BrTarget`. Go to EVAL. `PC` holds.
- **EVAL:**
  - `FlagSnap` <= `Flagin`.
  - taken = cond[4] | (`Flagin`[cond[2:0]] ^ cond[3]).
  - Taken: go to REDIRECT, `PC` holds.
  - Not taken: go to IDLE, `PC` <= `PC`+1.
- **REDIRECT:** `PC` <= latched target. `BrTaken` <= 1. Go to IDLE.
- **`BrTaken`:** cleared on every other edge.
- **`BrReq` in EVAL or REDIRECT:** ignored. The decoder must hold off while `BrBusy`=1.
- **Flag sampling point:** flags are sampled in EVAL, not at request time. A Flag register update landing on the request edge is therefore seen by the evaluation.

## Timing
- Request accepted at edge k (IDLE, no stall).
- **Not taken:** evaluation at edge k+1, `PC`+1 visible after k+1. Branch cost is 1 stall cycle.
- **Taken:** evaluation at k+1, target loaded at k+2. `BrTaken`=1 during the cycle k+2..k+3. Branch cost is 2 cycles.
- **`BrBusy`:** high from after edge k until after the edge that returns to IDLE.
- **Stalls:** each stalled edge adds exactly one cycle at the current state.
- **Reset mid-branch:** `Reset`=0 in EVAL or REDIRECT aborts the branch. No target load, no `BrTaken`. Reset values apply after that edge.
- **Reset and `Stall` together:** reset wins.
- **Back-to-back requests:** a new `BrReq` is accepted the first IDLE cycle after the return edge. No request is accepted on the return edge itself.

## Test plan
- **Reset then free-run:** `Reset`=0 for 2 edges, then 1, no requests. Required: `PC`=0, then 1, 2, 3 on successive edges. Preload `PC`=8'hFE and run 2 edges: `PC`=8'hFF, then 8'h00.
- **Taken conditional:** `Flagin`=8'h04, `BrReq`=1, `BrCond`=5'b00010 (bit 2), `BrTarget`=8'h40 at `PC`=8'h05. Required: `PC` 05 for two edges, then 40, `BrTaken` high one cycle, `FlagSnap`=8'h04.
- **Not taken and negated:**
  - `Flagin`=8'h03, `BrCond`=5'b00010: `PC` 05 -> 05 -> 06, no `BrTaken`.
  - Same with `BrCond`=5'b01010: taken to the target.
- **Unconditional:** `BrCond`=5'b10000, `Flagin`=8'h00, `BrTarget`=8'hA0. Required: `PC`=8'hA0 after 2 edges, `BrTaken` pulse.
- **Stall:** raise `Stall` for 3 cycles while in EVAL. Required: `PC`, `BrBusy`=1 and the state all hold, `BrTaken`=0. On release, resolution completes with the normal latency. A `BrReq` in IDLE while `Stall`=1 is ignored and `PC` is unchanged.
- **Reset mid-branch:** drive `Reset`=0 in REDIRECT with `BrTarget`=8'h40. Required: `PC`=0, `BrTaken`=0, `BrBusy`=0 after that edge, and the target is never loaded.
